alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU operand/result interface.
- Accepts operation commands over a valid/ready channel and drives A/B/select into a combinational ALU.
- Waits a fixed settle time, then captures Result/Zero and returns them, tagged, over a valid/ready response channel.
- Keeps completion counters and a sticky Zero-consistency error flag. Sits between a control sequencer and the ALU datapath.

Parameters:
DATA_W, 8, operand/result width
SEL_W, 3, ALU operation select width
TAG_W, 4, command tag width, echoed on response
SETTLE_CYCLES, 1, cycles operands are held before result capture (legal range 1..15)
CNT_W, 16, width of completion counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept command
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B
cmd_sel  in  SEL_W  ALU operation select
cmd_tag  in  TAG_W  command tag
alu_a  out  DATA_W  operand A to ALU
alu_b  out  DATA_W  operand B to ALU
alu_sel  out  SEL_W  select to ALU
alu_result  in  DATA_W  ALU result
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_result  out  DATA_W  captured result
rsp_zero  out  1  captured zero flag
rsp_tag  out  TAG_W  tag of completed command
busy  out  1  high in any state other than IDLE
op_count  out  CNT_W  completed responses, wraps
zero_count  out  CNT_W  completed responses with rsp_zero=1, wraps
zero_err  out  1  sticky: captured alu_zero disagreed with (alu_result==0)

Behaviour:
- Reset:
  - Applies when rst_n=0 at a rising edge, in any state, including mid-operation.
  - State goes to IDLE; all outputs and registers go to 0, except cmd_ready, which is 1 in IDLE.
  - Any in-flight command is dropped; no response is produced for it.
- FSM states: IDLE, SETTLE, RESP. cmd_ready = (state==IDLE), registered-state decode, no combinational path from cmd_valid.
- IDLE:
  - On cmd_valid & cmd_ready at edge E0: register cmd_a/b/sel into alu_a/b/sel and cmd_tag into the tag register.
  - Load settle counter with SETTLE_CYCLES, then go to SETTLE.
- SETTLE:
  - Counter decrements each edge. At the edge where the counter equals 1, sample alu_result/alu_zero into rsp_result/rsp_zero.
  - On that same edge: set rsp_valid=1 and go to RESP.
  - rsp_valid therefore rises SETTLE_CYCLES edges after E0.
- RESP:
  - rsp_valid, rsp_result, rsp_zero and rsp_tag are held stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid=0, op_count+1, zero_count+1 if rsp_zero, go to IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- Throughput: one command per SETTLE_CYCLES+2 cycles at best. No command is accepted while busy, and cmd_valid in non-IDLE states has no effect.
- alu_a/b/sel hold the last issued operands after completion. They change only on command acceptance or reset.
- rsp_result/rsp_zero/rsp_tag hold the last captured values after the handshake until the next capture.
- Zero check:
  - At the capture edge, if alu_zero != (alu_result==0), zero_err sets to 1.
  - zero_err stays 1 until reset. The response is still delivered unchanged.
- Counters wrap from 2^CNT_W-1 to 0 and never saturate.
- Arithmetic: the block never modifies data. Results pass through at DATA_W bits, with no sign handling.

Test Plan:
Bench ALU model: sel 0 = A+B mod 256, sel 1 = A-B mod 256, Zero = (Result==0), with an optional override to force a wrong Zero.
1. Reset, then command A=1 B=1 sel=0 tag=3, rsp_ready held 1, SETTLE_CYCLES=1 -> rsp_valid high 1 cycle after accept with result=2, zero=0, tag=3; op_count=1, cmd_ready high again 2 cycles after accept.
2. A=0xFF B=0x01 sel=0 -> result=0x00, zero=1, zero_count=1; wrap-around add checked.
3. Hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, a second cmd_valid with A=5 is not accepted; on rsp_ready=1 the handshake completes and the A=5 command is accepted the next cycle.
4. SETTLE_CYCLES=4 build, A=7 B=7 sel=1 -> rsp_valid rises exactly 4 edges after accept, result=0, zero=1.
5. Force Zero=0 while Result=0 -> response delivered with zero=0, zero_err=1 and stays 1 across later good ops until rst_n=0.
6. Assert rst_n=0 during SETTLE -> next edge: IDLE, rsp_valid=0, alu_a/b/sel=0, counters=0, zero_err=0; no response is ever produced for the dropped command.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Issues one ALU command at a time, holds operands for a settle time, returns tagged result.
// Latency: response valid SETTLE_CYCLES edges after accept; best throughput one cmd per SETTLE_CYCLES+2.
// Backpressure: cmd_ready only in IDLE; response held stable in RESP until rsp_ready.
module alu_cmd_issuer #(
    parameter int DATA_W        = 8,
    parameter int SEL_W         = 3,
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count,
    output logic [CNT_W-1:0]  zero_count,
    output logic              zero_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Settle counter only needs to cover 1..15.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       capture;
    logic       retire;
    logic [TAG_W-1:0] tag_q;

    // Handshake outputs are pure decodes of the registered state.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_tag   = tag_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and per-edge event strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/tag registers load only on acceptance, so they hold the last issued command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            tag_q   <= '0;
        end else if (accept) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
            tag_q   <= cmd_tag;
        end
    end

    // Settle countdown: loaded on accept, decremented while waiting for the ALU.
    always_ff @(posedge clk) begin
        if (!rst_n)                                   settle_cnt <= '0;
        else if (accept)                              settle_cnt <= SETTLE_LOAD;
        else if (state == SETTLE && settle_cnt != 0)  settle_cnt <= settle_cnt - 4'd1;
    end

    // Result capture and sticky zero-consistency check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            zero_err   <= 1'b0;
        end else if (capture) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            if (alu_zero != (alu_result == '0)) zero_err <= 1'b1;
        end
    end

    // Completion counters advance on the response handshake and wrap freely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count   <= '0;
            zero_count <= '0;
        end else if (retire) begin
            op_count <= op_count + 1'b1;
            if (rsp_zero) zero_count <= zero_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance 1: SETTLE_CYCLES=1
    logic       c1_valid = 0, c1_ready;
    logic [7:0] c1_a = 0, c1_b = 0;
    logic [2:0] c1_sel = 0;
    logic [3:0] c1_tag = 0;
    logic [7:0] a1, b1, res1, r1_result;
    logic [2:0] sel1;
    logic       z1, flip1 = 0;
    logic       r1_valid, r1_ready = 0, r1_zero, busy1, zerr1;
    logic [3:0] r1_tag;
    logic [15:0] opc1, zc1;

    // Instance 2: SETTLE_CYCLES=4
    logic       c2_valid = 0, c2_ready;
    logic [7:0] c2_a = 0, c2_b = 0;
    logic [2:0] c2_sel = 0;
    logic [3:0] c2_tag = 0;
    logic [7:0] a2, b2, res2, r2_result;
    logic [2:0] sel2;
    logic       z2;
    logic       r2_valid, r2_ready = 0, r2_zero, busy2, zerr2;
    logic [3:0] r2_tag;
    logic [15:0] opc2, zc2;

    // Bench ALU model: sel 0 add, otherwise subtract; zero optionally flipped.
    assign res1 = (sel1 == 3'd0) ? a1 + b1 : a1 - b1;
    assign z1   = (res1 == 8'd0) ^ flip1;
    assign res2 = (sel2 == 3'd0) ? a2 + b2 : a2 - b2;
    assign z2   = (res2 == 8'd0);

    alu_cmd_issuer #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready),
        .cmd_a(c1_a), .cmd_b(c1_b), .cmd_sel(c1_sel), .cmd_tag(c1_tag),
        .alu_a(a1), .alu_b(b1), .alu_sel(sel1),
        .alu_result(res1), .alu_zero(z1),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready),
        .rsp_result(r1_result), .rsp_zero(r1_zero), .rsp_tag(r1_tag),
        .busy(busy1), .op_count(opc1), .zero_count(zc1), .zero_err(zerr1)
    );

    alu_cmd_issuer #(.SETTLE_CYCLES(4)) u2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_a(c2_a), .cmd_b(c2_b), .cmd_sel(c2_sel), .cmd_tag(c2_tag),
        .alu_a(a2), .alu_b(b2), .alu_sel(sel2),
        .alu_result(res2), .alu_zero(z2),
        .rsp_valid(r2_valid), .rsp_ready(r2_ready),
        .rsp_result(r2_result), .rsp_zero(r2_zero), .rsp_tag(r2_tag),
        .busy(busy2), .op_count(opc2), .zero_count(zc2), .zero_err(zerr2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, input logic [3:0] t);
        c1_valid = 1'b1; c1_a = a; c1_b = b; c1_sel = s; c1_tag = t;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", 32'(c1_ready), 1);
        chk("rst_rsp_valid", 32'(r1_valid), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_op_count", 32'(opc1), 0);
        chk("rst_zero_err", 32'(zerr1), 0);
        chk("rst_alu_a", 32'(a1), 0);
        rst_n = 1'b1;

        // 1: 1+1, tag 3, rsp_ready held high
        r1_ready = 1'b1;
        cmd1(8'd1, 8'd1, 3'd0, 4'd3);
        tick();                                   // accept edge
        c1_valid = 1'b0;
        chk("t1_alu_a", 32'(a1), 1);
        chk("t1_cmd_ready_busy", 32'(c1_ready), 0);
        chk("t1_rsp_valid_early", 32'(r1_valid), 0);
        tick();                                   // capture edge
        chk("t1_rsp_valid", 32'(r1_valid), 1);
        chk("t1_result", 32'(r1_result), 2);
        chk("t1_zero", 32'(r1_zero), 0);
        chk("t1_tag", 32'(r1_tag), 3);
        tick();                                   // handshake edge
        chk("t1_cmd_ready_again", 32'(c1_ready), 1);
        chk("t1_rsp_valid_low", 32'(r1_valid), 0);
        chk("t1_op_count", 32'(opc1), 1);

        // 2: 0xFF+0x01 wraps to zero
        cmd1(8'hFF, 8'h01, 3'd0, 4'd5);
        tick();
        c1_valid = 1'b0;
        tick();
        chk("t2_result", 32'(r1_result), 0);
        chk("t2_zero", 32'(r1_zero), 1);
        chk("t2_tag", 32'(r1_tag), 5);
        tick();
        chk("t2_zero_count", 32'(zc1), 1);
        chk("t2_op_count", 32'(opc1), 2);

        // 3: response backpressure, second command blocked
        r1_ready = 1'b0;
        cmd1(8'd9, 8'd2, 3'd1, 4'd6);
        tick();
        c1_valid = 1'b0;
        tick();                                   // now in RESP
        cmd1(8'd5, 8'd0, 3'd0, 4'd7);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", 32'(r1_valid), 1);
            chk("t3_hold_result", 32'(r1_result), 7);
            chk("t3_hold_tag", 32'(r1_tag), 6);
            chk("t3_cmd_ready_low", 32'(c1_ready), 0);
            chk("t3_alu_a_kept", 32'(a1), 9);
        end
        r1_ready = 1'b1;
        tick();                                   // handshake
        chk("t3_op_count", 32'(opc1), 3);
        chk("t3_cmd_ready", 32'(c1_ready), 1);
        chk("t3_result_held", 32'(r1_result), 7);
        tick();                                   // A=5 accepted
        c1_valid = 1'b0;
        chk("t3_second_alu_a", 32'(a1), 5);
        chk("t3_second_busy", 32'(busy1), 1);
        tick();
        chk("t3_second_result", 32'(r1_result), 5);
        chk("t3_second_tag", 32'(r1_tag), 7);
        tick();
        chk("t3_op_count2", 32'(opc1), 4);

        // 4: SETTLE_CYCLES=4 instance, 7-7
        r2_ready = 1'b1;
        c2_valid = 1'b1; c2_a = 8'd7; c2_b = 8'd7; c2_sel = 3'd1; c2_tag = 4'd9;
        tick();                                   // accept
        c2_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t4_rsp_not_yet", 32'(r2_valid), 0);
        end
        tick();                                   // 4th edge after accept
        chk("t4_rsp_valid", 32'(r2_valid), 1);
        chk("t4_result", 32'(r2_result), 0);
        chk("t4_zero", 32'(r2_zero), 1);
        chk("t4_tag", 32'(r2_tag), 9);
        tick();
        chk("t4_op_count", 32'(opc2), 1);
        chk("t4_zero_count", 32'(zc2), 1);
        chk("t4_cmd_ready", 32'(c2_ready), 1);

        // 5: forced wrong zero flag
        flip1 = 1'b1;
        cmd1(8'd3, 8'd3, 3'd1, 4'd2);
        tick();
        c1_valid = 1'b0;
        tick();
        chk("t5_result", 32'(r1_result), 0);
        chk("t5_zero_passthru", 32'(r1_zero), 0);
        chk("t5_zero_err", 32'(zerr1), 1);
        flip1 = 1'b0;
        tick();
        chk("t5_zero_count", 32'(zc1), 1);
        chk("t5_op_count", 32'(opc1), 5);
        cmd1(8'd2, 8'd1, 3'd0, 4'd4);
        tick();
        c1_valid = 1'b0;
        tick();
        chk("t5_good_result", 32'(r1_result), 3);
        tick();
        chk("t5_zero_err_sticky", 32'(zerr1), 1);
        chk("t5_op_count2", 32'(opc1), 6);

        // 6: reset during SETTLE drops the command
        cmd1(8'd4, 8'd4, 3'd1, 4'd1);
        tick();
        c1_valid = 1'b0;
        chk("t6_busy", 32'(busy1), 1);
        rst_n = 1'b0;
        tick();
        chk("t6_cmd_ready", 32'(c1_ready), 1);
        chk("t6_rsp_valid", 32'(r1_valid), 0);
        chk("t6_alu_a", 32'(a1), 0);
        chk("t6_alu_b", 32'(b1), 0);
        chk("t6_alu_sel", 32'(sel1), 0);
        chk("t6_op_count", 32'(opc1), 0);
        chk("t6_zero_count", 32'(zc1), 0);
        chk("t6_zero_err", 32'(zerr1), 0);
        chk("t6_rsp_tag", 32'(r1_tag), 0);
        chk("t6_op_count_u2", 32'(opc2), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_rsp", 32'(r1_valid), 0);
            chk("t6_no_count", 32'(opc1), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
